iter_mul_unit: RTL and testbench
================================

Name: iter_mul_unit

Overview:
- Parametrised multi-cycle integer multiplier serving the MUL instruction of the pipelined MIPS core.
- Replaces the single-cycle combinational multiply in the EX stage.
- Adds configurable width, radix (bits retired per cycle), signed/unsigned mode, full double-width product, overflow flag, and an abort path for pipeline flush on a taken branch.
- Sits beside the EX-stage ALU; the pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 8.
- RADIX_BITS, 1, multiplier bits consumed per RUN cycle; legal values 1, 2, 4; WIDTH must be divisible by RADIX_BITS.
- SIGNED_EN, 1, when 0 the `is_signed` input is ignored and treated as 0.

Ports:
- clk1  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  flush; cancels any operation in progress.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- busy  output  1  operation in progress; pipeline stall request.
- done  output  1  one-cycle pulse; result valid.
- result_lo  output  WIDTH  low half of the product.
- result_hi  output  WIDTH  high half of the product.
- overflow  output  1  product does not fit in WIDTH bits.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, overflow = 0.
  - result_lo = 0, result_hi = 0.
  - All internal accumulators = 0.
- Let N = WIDTH/RADIX_BITS.
- State machine: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On start=1 and abort=0 at edge E0:
    - latch |op_a| and |op_b| as WIDTH-bit unsigned magnitudes; |-2^(WIDTH-1)| = 2^(WIDTH-1), no saturation.
    - latch neg = is_signed & (op_a[msb] ^ op_b[msb]).
    - clear the 2*WIDTH accumulator and the step counter.
    - busy rises at E0.
- RUN:
  - Each edge adds (|a| * next RADIX_BITS multiplier digit) shifted into the accumulator; shift-add, LSB digit first.
  - Exactly N edges, E1..EN.
  - Counter width is clog2(N+1).
- FIX (edge EN+1):
  - accumulator negated (two's complement over 2*WIDTH bits) if neg.
  - result_hi/result_lo registered.
  - done=1, busy=0; state returns to IDLE.
- Latency: done rises on edge E(N+1) and is high for exactly one cycle; 33 edges for 32/1, 9 edges for 32/4.
- Results and overflow hold their values until the next FIX; they are unchanged by start, abort or idle cycles.
- Overflow:
  - unsigned: result_hi != 0.
  - signed: result_hi != {WIDTH{result_lo[msb]}}.
- Back-to-back: start sampled in the same cycle done is high is accepted; busy stays 0 for at most that one cycle.
- start while busy: ignored; no queuing.
- abort:
  - Any state, next edge: go to IDLE, busy=0, done stays 0.
  - Results are not updated.
  - abort and start together in IDLE: abort wins, start is dropped.
- Operand inputs need not be held after E0.
- Reset mid-operation: immediate return to reset values; no done.
- Zero operands still take the full N+1 edges; there is no early termination.

Decomposition:
- Shared package `mips_pkg`:
  - WORD_WIDTH=32.
  - opcode constant OP_MUL=6'h05.
  - state localparams ST_IDLE, ST_RUN, ST_FIX (2-bit).
  - helper function clog2.
- One sub-module `mul_pp_step`: combinational radix-2^RADIX_BITS partial-product-and-add step (acc_in, mcand, digit -> acc_out), instantiated once inside RUN.
- The FSM and negate/overflow logic stay in `iter_mul_unit`.

Test Plan:
- Factorial chain, 32/1 unsigned:
  - stimulus: mul 1*5, then result*4, *3, *2, each started on its done cycle.
  - required: final result_lo=120, result_hi=0, overflow=0; each done exactly 33 edges after its start.
- Signed, 32/1:
  - stimulus: op_a=-3 (0xFFFFFFFD), op_b=7, is_signed=1.
  - required: result_lo=0xFFFFFFEB, result_hi=0xFFFFFFFF, overflow=0.
- Unsigned, max operands:
  - stimulus: 0xFFFFFFFF*0xFFFFFFFF, is_signed=0.
  - required: result_hi=0xFFFFFFFE, result_lo=0x00000001, overflow=1.
  - then same operands with is_signed=1 -> result_lo=1, result_hi=0, overflow=0.
- Radix 4 (RADIX_BITS=4), signed:
  - stimulus: 0x80000000*0x80000000, is_signed=1.
  - required: done at edge 9; result_hi=0x40000000, result_lo=0, overflow=1.
- Abort:
  - stimulus: start 6*7, abort at edge 10.
  - required: busy=0 after edge 11, no done pulse, previous results unchanged.
  - a start then issued yields 42.
- Reset mid-operation:
  - stimulus: rst_n low at edge 15 of an operation.
  - required: all outputs 0 immediately; a later 2*3 returns 6 with correct latency; start while busy is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core blocks: word width, opcodes,
// multiplier FSM states and a constant-evaluable ceil(log2) helper.
package mips_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic [5:0] OP_MUL = 6'h05;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } mul_state_t;

  // Smallest r such that 2**r >= value; usable in localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_pp_step.sv
// One shift-add step of an unsigned radix-2^RADIX_BITS multiplier.
// The running product sits in the top of a 2*WIDTH accumulator; each step
// adds mcand*digit at bit WIDTH and shifts right by RADIX_BITS, so after
// WIDTH/RADIX_BITS steps the accumulator holds the exact full product.
module mul_pp_step #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic [2*WIDTH-1:0]    i_acc,
  input  logic [WIDTH-1:0]      i_mcand,
  input  logic [RADIX_BITS-1:0] i_digit,
  output logic [2*WIDTH-1:0]    o_acc
);

  localparam int PW = WIDTH + RADIX_BITS;
  localparam int SW = 2 * WIDTH + RADIX_BITS;

  logic [PW-1:0] w_pp;
  logic [SW-1:0] w_sum;

  // The sum needs RADIX_BITS of headroom before the shift brings it back
  // into 2*WIDTH bits; the shifted-out low bits are always zero-weight.
  assign w_pp  = PW'(i_mcand) * PW'(i_digit);
  assign w_sum = SW'(i_acc) + {w_pp, {WIDTH{1'b0}}};
  assign o_acc = (2 * WIDTH)'(w_sum >> RADIX_BITS);

endmodule

// File: rtl/iter_mul_unit.sv
// Multi-cycle integer multiplier for the EX stage MUL instruction.
// Multiplies operand magnitudes with a shift-add datapath, then fixes the
// sign and flags overflow in a final cycle.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | waiting for start; results/overflow hold last product
//   ST_RUN  | one partial-product step per cycle, WIDTH/RADIX_BITS cycles
//   ST_FIX  | apply sign, register product and overflow, pulse done
module iter_mul_unit
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1,
  parameter bit SIGNED_EN  = 1'b1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow
);

  localparam int            N    = WIDTH / RADIX_BITS;
  localparam int            CW   = clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  mul_state_t r_state;
  mul_state_t w_state_nxt;

  logic               w_load;
  logic               w_step;
  logic               w_commit;
  logic               w_sgn;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_acc_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_prod_hi;
  logic [WIDTH-1:0]   w_prod_lo;
  logic               w_ovf;

  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic               r_neg;
  logic               r_sgn;
  logic               r_done;
  logic               r_overflow;
  logic [WIDTH-1:0]   r_result_lo;
  logic [WIDTH-1:0]   r_result_hi;

  assign w_sgn = SIGNED_EN & is_signed;

  // Unary minus of the most negative value wraps to itself, which read as
  // unsigned is exactly its magnitude, so no saturation is needed.
  assign w_mag_a = (w_sgn && op_a[WIDTH-1]) ? -op_a : op_a;
  assign w_mag_b = (w_sgn && op_b[WIDTH-1]) ? -op_b : op_b;

  mul_pp_step #(
    .WIDTH      (WIDTH),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_digit (r_mplier[RADIX_BITS-1:0]),
    .o_acc   (w_acc_step)
  );

  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH];
  assign w_prod_lo = w_prod[WIDTH-1:0];
  assign w_ovf     = r_sgn ? (w_prod_hi != {WIDTH{w_prod_lo[WIDTH-1]}})
                           : (w_prod_hi != '0);

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and datapath strobes; abort overrides everything, including
  // a start seen in the same cycle and the commit of a finished product.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_commit    = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_load      = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          w_step = 1'b1;
          if (r_cnt == LAST) w_state_nxt = ST_FIX;
        end
        ST_FIX: begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand capture and shift-add accumulation, LSB digit first.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_sgn    <= 1'b0;
    end else if (w_load) begin
      r_mcand  <= w_mag_a;
      r_mplier <= w_mag_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= w_sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      r_sgn    <= w_sgn;
    end else if (w_step) begin
      r_acc    <= w_acc_step;
      r_mplier <= r_mplier >> RADIX_BITS;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result registers change only on a committed product; done pulses once.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_result_lo <= '0;
      r_result_hi <= '0;
    end else begin
      r_done <= w_commit;
      if (w_commit) begin
        r_result_lo <= w_prod_lo;
        r_result_hi <= w_prod_hi;
        r_overflow  <= w_ovf;
      end
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign result_lo = r_result_lo;
  assign result_hi = r_result_hi;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Self-checking bench for iter_mul_unit: a radix-2 and a radix-16 instance
// checked against an arithmetic reference model.
module tb_iter_mul_unit;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        abort = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;

  logic        busy, done, overflow;
  logic [31:0] result_lo, result_hi;
  logic        busy4, done4, overflow4;
  logic [31:0] result_lo4, result_hi4;

  int checks = 0;
  int errors = 0;

  // last product committed by the radix-1 instance, per the model
  logic [31:0] exp_lo  = '0;
  logic [31:0] exp_hi  = '0;
  logic        exp_ovf = 1'b0;

  always #5 clk1 = ~clk1;

  iter_mul_unit #(.WIDTH(32), .RADIX_BITS(1), .SIGNED_EN(1'b1)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result_lo(result_lo),
    .result_hi(result_hi), .overflow(overflow)
  );

  iter_mul_unit #(.WIDTH(32), .RADIX_BITS(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk1(clk1), .rst_n(rst_n), .start(start4), .abort(abort),
    .is_signed(is_signed), .op_a(op_a), .op_b(op_b),
    .busy(busy4), .done(done4), .result_lo(result_lo4),
    .result_hi(result_hi4), .overflow(overflow4)
  );

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
    longint sa, sb;
    logic [63:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return sa * sb;
    end
    ua = {32'h0, a};
    ub = {32'h0, b};
    return ua * ub;
  endfunction

  function automatic logic model_ovf(input logic [63:0] p, input logic sgn);
    longint sp, lim;
    logic [63:0] q;
    if (sgn) begin
      sp  = longint'(p);
      lim = 64'sh80000000;
      return (sp >= lim) || (sp < -lim);
    end
    q = p >> 32;
    return q != 0;
  endfunction

  // Issues one multiply and returns the edge count from E0 to the done
  // pulse (-1 if it never came); leaves time in the done-high cycle.
  task automatic do_mul(input bit use4, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, output int lat);
    op_a = a; op_b = b; is_signed = sgn;
    if (use4) start4 = 1'b1; else start = 1'b1;
    tick;
    start = 1'b0; start4 = 1'b0;
    op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom_range(0, 1));
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if ((use4 ? done4 : done) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) tick;
    checks++;
    if ({busy, done, overflow, result_hi, result_lo} !== 67'h0) begin
      errors++;
      $display("FAIL reset_r1 got %h exp 0", {busy, done, overflow, result_hi, result_lo});
    end
    checks++;
    if ({busy4, done4, overflow4, result_hi4, result_lo4} !== 67'h0) begin
      errors++;
      $display("FAIL reset_r4 got %h exp 0", {busy4, done4, overflow4, result_hi4, result_lo4});
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_factorial;
    logic [31:0] mults [4] = '{32'd5, 32'd4, 32'd3, 32'd2};
    logic [31:0] run = 32'd1;
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 4; i++) begin
      p = model_prod(run, mults[i], 1'b0);
      do_mul(1'b0, run, mults[i], 1'b0, lat);
      checks++;
      if (lat != 33) begin
        errors++; $display("FAIL fact_latency step %0d got %0d exp 33", i, lat);
      end
      checks++;
      if (result_lo !== p[31:0]) begin
        errors++; $display("FAIL fact_lo step %0d got %h exp %h", i, result_lo, p[31:0]);
      end
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL fact_busy_on_done step %0d got %b exp 0", i, busy);
      end
      run = p[31:0];
      exp_lo = p[31:0]; exp_hi = p[63:32]; exp_ovf = model_ovf(p, 1'b0);
    end
    checks++;
    if ({result_hi, result_lo, overflow} !== {32'd0, 32'd120, 1'b0}) begin
      errors++;
      $display("FAIL fact_final got hi %h lo %h ovf %b exp 0/78/0", result_hi, result_lo, overflow);
    end
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL fact_idle_after got busy %b exp 0", busy);
    end
  endtask

  task automatic test_signed;
    int lat;
    do_mul(1'b0, 32'hFFFFFFFD, 32'd7, 1'b1, lat);
    checks++;
    if ({result_hi, result_lo, overflow} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0} || lat != 33) begin
      errors++;
      $display("FAIL signed_m3x7 got hi %h lo %h ovf %b lat %0d exp ffffffff/ffffffeb/0/33",
               result_hi, result_lo, overflow, lat);
    end
    exp_hi = 32'hFFFFFFFF; exp_lo = 32'hFFFFFFEB; exp_ovf = 1'b0;
    tick;
  endtask

  task automatic test_max;
    int lat;
    do_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, lat);
    checks++;
    if ({result_hi, result_lo, overflow} !== {32'hFFFFFFFE, 32'h00000001, 1'b1}) begin
      errors++;
      $display("FAIL max_unsigned got hi %h lo %h ovf %b exp fffffffe/00000001/1",
               result_hi, result_lo, overflow);
    end
    tick;
    do_mul(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat);
    checks++;
    if ({result_hi, result_lo, overflow} !== {32'h0, 32'h1, 1'b0}) begin
      errors++;
      $display("FAIL max_signed got hi %h lo %h ovf %b exp 0/1/0", result_hi, result_lo, overflow);
    end
    exp_hi = 32'h0; exp_lo = 32'h1; exp_ovf = 1'b0;
    tick;
  endtask

  task automatic test_random;
    logic [31:0] corner [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000FFFF};
    logic [31:0] a, b;
    logic        s;
    logic [63:0] p;
    int lat;
    for (int i = 0; i < 14; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      s = 1'($urandom_range(0, 1));
      p = model_prod(a, b, s);
      do_mul(1'b0, a, b, s, lat);
      checks++;
      if ({result_hi, result_lo, overflow} !== {p, model_ovf(p, s)} || lat != 33) begin
        errors++;
        $display("FAIL random_%0d a %h b %h s %b got %h%h ovf %b lat %0d exp %h ovf %b lat 33",
                 i, a, b, s, result_hi, result_lo, overflow, lat, p, model_ovf(p, s));
      end
      exp_hi = p[63:32]; exp_lo = p[31:0]; exp_ovf = model_ovf(p, s);
      repeat ($urandom_range(0, 2)) tick;
    end
    tick;
  endtask

  task automatic test_radix4;
    logic [31:0] a, b;
    logic        s;
    logic [63:0] p;
    int lat;
    do_mul(1'b1, 32'h80000000, 32'h80000000, 1'b1, lat);
    checks++;
    if (lat != 9) begin
      errors++; $display("FAIL r4_latency got %0d exp 9", lat);
    end
    checks++;
    if ({result_hi4, result_lo4, overflow4} !== {32'h40000000, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL r4_minxmin got hi %h lo %h ovf %b exp 40000000/0/1",
               result_hi4, result_lo4, overflow4);
    end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      p = model_prod(a, b, s);
      do_mul(1'b1, a, b, s, lat);
      checks++;
      if ({result_hi4, result_lo4, overflow4} !== {p, model_ovf(p, s)} || lat != 9) begin
        errors++;
        $display("FAIL r4_random_%0d a %h b %h s %b got %h%h ovf %b lat %0d exp %h ovf %b lat 9",
                 i, a, b, s, result_hi4, result_lo4, overflow4, lat, p, model_ovf(p, s));
      end
    end
    tick;
  endtask

  task automatic test_abort;
    int seen;
    int lat;
    tick;
    op_a = 32'd6; op_b = 32'd7; is_signed = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL abort_busy_before got %b exp 1", busy);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_busy_after got %b exp 0", busy);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_done got %0d pulses exp 0", seen);
    end
    checks++;
    if ({result_hi, result_lo, overflow} !== {exp_hi, exp_lo, exp_ovf}) begin
      errors++;
      $display("FAIL abort_hold got %h%h ovf %b exp %h%h ovf %b",
               result_hi, result_lo, overflow, exp_hi, exp_lo, exp_ovf);
    end
    do_mul(1'b0, 32'd6, 32'd7, 1'b0, lat);
    checks++;
    if ({result_hi, result_lo, overflow} !== {32'd0, 32'd42, 1'b0} || lat != 33) begin
      errors++;
      $display("FAIL abort_then_42 got hi %h lo %h ovf %b lat %0d exp 0/2a/0/33",
               result_hi, result_lo, overflow, lat);
    end
    exp_hi = 32'd0; exp_lo = 32'd42; exp_ovf = 1'b0;
    tick;
    op_a = 32'd9; op_b = 32'd9; start = 1'b1; abort = 1'b1;
    tick;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL abort_wins_busy got %b exp 0", busy);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || result_lo !== exp_lo) begin
      errors++;
      $display("FAIL abort_wins_drop got %0d pulses lo %h exp 0 pulses lo %h", seen, result_lo, exp_lo);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int seen;
    op_a = 32'd5; op_b = 32'd9; is_signed = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (14) tick;
    @(posedge clk1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, overflow, result_hi, result_lo} !== 67'h0) begin
      errors++;
      $display("FAIL rstmid_r1 got %h exp 0", {busy, done, overflow, result_hi, result_lo});
    end
    checks++;
    if ({busy4, done4, overflow4, result_hi4, result_lo4} !== 67'h0) begin
      errors++;
      $display("FAIL rstmid_r4 got %h exp 0", {busy4, done4, overflow4, result_hi4, result_lo4});
    end
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
    op_a = 32'd2; op_b = 32'd3; is_signed = 1'b0; start = 1'b1;
    tick;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      end else begin
        start = 1'b0;
      end
      tick;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if ({result_hi, result_lo, overflow} !== {32'd0, 32'd6, 1'b0} || lat != 33) begin
      errors++;
      $display("FAIL rstmid_2x3 got hi %h lo %h ovf %b lat %0d exp 0/6/0/33",
               result_hi, result_lo, overflow, lat);
    end
    tick;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy === 1'b1 || done === 1'b1) seen++;
      tick;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL busy_start_ignored got %0d active cycles exp 0", seen);
    end
  endtask

  initial begin
    test_reset;
    test_factorial;
    test_signed;
    test_max;
    test_random;
    test_radix4;
    test_abort;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
